leiwand_rv32_wb_decoder: RTL and testbench

Parametrised Wishbone (pipelined) address decoder and response router between the leiwand_rv32 core master and NR_SLAVES slaves (SRAM, ROM, peripherals). It replaces ad-hoc range compares and OR-combined slave responses. It tracks the single outstanding transaction, routes only the selected slave's ack/data/stall back to the master, and raises a bus error on an unmapped address or a slave timeout.

---
 rtl/leiwand_rv32_wb_decoder_pkg.sv | 21 ++
 rtl/leiwand_rv32_wb_addr_match.sv | 47 ++++
 rtl/leiwand_rv32_wb_decoder.sv | 136 +++++++++++++
 tb/tb_leiwand_rv32_wb_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leiwand_rv32_wb_decoder_pkg.sv
// Shared types and constants for the leiwand_rv32 Wishbone decoder.
// Default SoC memory map and decoder FSM state encoding.
package leiwand_rv32_wb_decoder_pkg;

    typedef enum logic [1:0] {
        WB_DEC_IDLE = 2'd0,
        WB_DEC_BUSY = 2'd1,
        WB_DEC_ERR  = 2'd2
    } wb_dec_state_t;

    localparam logic [31:0] SRAM_BASE = 32'h1000_0000;
    localparam logic [31:0] SRAM_SIZE = 32'h0000_4000;
    localparam logic [31:0] ROM_BASE  = 32'h2040_0000;
    localparam logic [31:0] ROM_SIZE  = 32'h0000_4000;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int high_bit_to_fit(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leiwand_rv32_wb_addr_match.sv
// Per-slave address range compare plus lowest-index priority encoder.
// Ranges are compared one bit wider so a region ending at 2^MEM_WIDTH works.
module leiwand_rv32_wb_addr_match
    import leiwand_rv32_wb_decoder_pkg::*;
#(
    parameter int NR_SLAVES = 4,
    parameter int MEM_WIDTH = 32,
    parameter logic [NR_SLAVES*MEM_WIDTH-1:0] SLAVE_BASES =
        {32'h0, 32'h0, ROM_BASE, SRAM_BASE},
    parameter logic [NR_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZES =
        {32'h0, 32'h0, ROM_SIZE, SRAM_SIZE},
    parameter int SEL_W = high_bit_to_fit(NR_SLAVES)
) (
    input  logic [MEM_WIDTH-1:0] addr,
    output logic [NR_SLAVES-1:0] hit,
    output logic [SEL_W-1:0]     idx,
    output logic                 miss
);

    logic [MEM_WIDTH:0] addr_x;

    assign addr_x = {1'b0, addr};

    for (genvar k = 0; k < NR_SLAVES; k++) begin : g_cmp
        localparam logic [MEM_WIDTH-1:0] SIZE =
            SLAVE_SIZES[k*MEM_WIDTH +: MEM_WIDTH];
        localparam logic [MEM_WIDTH:0] LO =
            {1'b0, SLAVE_BASES[k*MEM_WIDTH +: MEM_WIDTH]};
        localparam logic [MEM_WIDTH:0] HI = LO + {1'b0, SIZE};
        if (SIZE != '0) begin : g_en
            assign hit[k] = (addr_x >= LO) && (addr_x < HI);
        end else begin : g_off
            assign hit[k] = 1'b0;
        end
    end

    // Lowest-numbered hit wins when regions overlap.
    always_comb begin
        idx = '0;
        for (int k = NR_SLAVES - 1; k >= 0; k--) begin
            if (hit[k]) idx = SEL_W'(k);
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/leiwand_rv32_wb_decoder.sv
// Wishbone pipelined address decoder and response router.
// Tracks one outstanding transaction; errors on unmapped address or timeout.
module leiwand_rv32_wb_decoder
    import leiwand_rv32_wb_decoder_pkg::*;
#(
    parameter int NR_SLAVES = 4,
    parameter int MEM_WIDTH = 32,
    parameter logic [NR_SLAVES*MEM_WIDTH-1:0] SLAVE_BASES =
        {32'h0, 32'h0, ROM_BASE, SRAM_BASE},
    parameter logic [NR_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZES =
        {32'h0, 32'h0, ROM_SIZE, SRAM_SIZE},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [MEM_WIDTH-1:0]           m_addr,
    input  logic [MEM_WIDTH-1:0]           m_data_out,
    input  logic                           m_we,
    input  logic                           m_stb,
    input  logic                           m_cyc,
    output logic [MEM_WIDTH-1:0]           m_data_in,
    output logic                           m_ack,
    output logic                           m_stall,
    output logic                           m_err,
    output logic [MEM_WIDTH-1:0]           s_addr,
    output logic [MEM_WIDTH-1:0]           s_data_out,
    output logic                           s_we,
    output logic [NR_SLAVES-1:0]           s_cyc,
    output logic [NR_SLAVES-1:0]           s_stb,
    input  logic [NR_SLAVES*MEM_WIDTH-1:0] s_data_in,
    input  logic [NR_SLAVES-1:0]           s_ack,
    input  logic [NR_SLAVES-1:0]           s_stall
);

    localparam int SEL_W = high_bit_to_fit(NR_SLAVES);
    localparam int CNT_W = high_bit_to_fit(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_dec_state_t        state, state_nxt;
    logic [SEL_W-1:0]     sel;
    logic [CNT_W-1:0]     cnt;
    logic [NR_SLAVES-1:0] hit;
    logic [SEL_W-1:0]     idx;
    logic                 miss;
    logic                 go_busy;
    logic [MEM_WIDTH-1:0] s_rdata [NR_SLAVES];

    assign s_addr     = m_addr;
    assign s_data_out = m_data_out;
    assign s_we       = m_we;

    for (genvar k = 0; k < NR_SLAVES; k++) begin : g_rd
        assign s_rdata[k] = s_data_in[k*MEM_WIDTH +: MEM_WIDTH];
    end

    leiwand_rv32_wb_addr_match #(
        .NR_SLAVES   (NR_SLAVES),
        .MEM_WIDTH   (MEM_WIDTH),
        .SLAVE_BASES (SLAVE_BASES),
        .SLAVE_SIZES (SLAVE_SIZES),
        .SEL_W       (SEL_W)
    ) u_match (
        .addr (m_addr),
        .hit  (hit),
        .idx  (idx),
        .miss (miss)
    );

    // Next state and all master/slave handshake outputs; quiet while in reset.
    always_comb begin
        state_nxt = state;
        go_busy   = 1'b0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_stall   = 1'b0;
        m_data_in = '0;
        s_stb     = '0;
        s_cyc     = '0;
        if (!reset) begin
            unique case (state)
                WB_DEC_IDLE: begin
                    if (m_cyc && m_stb) begin
                        if (!miss && hit[idx]) begin
                            s_stb[idx] = 1'b1;
                            s_cyc[idx] = 1'b1;
                            m_stall    = s_stall[idx];
                            if (!s_stall[idx]) begin
                                go_busy   = 1'b1;
                                state_nxt = WB_DEC_BUSY;
                            end
                        end else begin
                            state_nxt = WB_DEC_ERR;
                        end
                    end
                end
                WB_DEC_BUSY: begin
                    m_stall    = 1'b1;
                    s_cyc[sel] = m_cyc;
                    if (!m_cyc) begin
                        state_nxt = WB_DEC_IDLE;
                    end else if (s_ack[sel]) begin
                        m_ack     = 1'b1;
                        m_data_in = s_rdata[sel];
                        state_nxt = WB_DEC_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        m_err     = 1'b1;
                        state_nxt = WB_DEC_IDLE;
                    end
                end
                WB_DEC_ERR: begin
                    m_err     = 1'b1;
                    state_nxt = WB_DEC_IDLE;
                end
                default: state_nxt = WB_DEC_IDLE;
            endcase
        end
    end

    // State, selected slave and timeout counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WB_DEC_IDLE;
            sel   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (go_busy) begin
                sel <= idx;
                cnt <= '0;
            end else if (state == WB_DEC_BUSY && !s_ack[sel]) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_wb_decoder.sv
// Directed bench for leiwand_rv32_wb_decoder with a transaction-level model.
// The model is checked every cycle; literal checks pin the key scenarios.
module tb_leiwand_rv32_wb_decoder;

    localparam int NS = 4;
    localparam int MW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [MW-1:0] m_addr, m_data_out;
    logic          m_we, m_stb, m_cyc;
    logic [MW-1:0] m_data_in;
    logic          m_ack, m_stall, m_err;
    logic [MW-1:0] s_addr, s_data_out;
    logic          s_we;
    logic [NS-1:0] s_cyc, s_stb;
    logic [NS*MW-1:0] s_data_in;
    logic [NS-1:0] s_ack, s_stall;
    logic [MW-1:0] sdata [NS];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NS; k++) begin : g_sd
        assign s_data_in[k*MW +: MW] = sdata[k];
    end

    leiwand_rv32_wb_decoder #(
        .NR_SLAVES      (NS),
        .MEM_WIDTH      (MW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_addr     (m_addr),
        .m_data_out (m_data_out),
        .m_we       (m_we),
        .m_stb      (m_stb),
        .m_cyc      (m_cyc),
        .m_data_in  (m_data_in),
        .m_ack      (m_ack),
        .m_stall    (m_stall),
        .m_err      (m_err),
        .s_addr     (s_addr),
        .s_data_out (s_data_out),
        .s_we       (s_we),
        .s_cyc      (s_cyc),
        .s_stb      (s_stb),
        .s_data_in  (s_data_in),
        .s_ack      (s_ack),
        .s_stall    (s_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Memory map as plain numbers.
    longint mbase [NS] = '{64'h1000_0000, 64'h2040_0000, 64'h0, 64'h0};
    longint msize [NS] = '{64'h4000, 64'h4000, 64'h0, 64'h0};

    function automatic int decode(input logic [MW-1:0] a);
        longint av;
        av = longint'(a);
        for (int k = 0; k < NS; k++) begin
            if (msize[k] != 0 && av >= mbase[k] && av < mbase[k] + msize[k])
                return k;
        end
        return -1;
    endfunction

    // Outstanding transaction: slave index (-1 none), busy cycles elapsed,
    // and a pending unmapped-address error.
    int busy_k = -1, age = 0, nx_k = -1, nx_age = 0;
    bit errp = 1'b0, nx_errp = 1'b0;
    int acc0 = 0;

    always @(negedge clk) begin
        logic          e_ack, e_err, e_stall;
        logic [MW-1:0] e_data;
        logic [NS-1:0] e_stb, e_cyc;
        int            k;
        e_ack = 0; e_err = 0; e_stall = 0; e_data = '0;
        e_stb = '0; e_cyc = '0;
        nx_k = busy_k; nx_age = age; nx_errp = 0;
        if (reset) begin
            nx_k = -1; nx_age = 0;
        end else if (errp) begin
            e_err = 1;
        end else if (busy_k >= 0) begin
            e_stall = 1;
            e_cyc[busy_k] = m_cyc;
            if (!m_cyc) nx_k = -1;
            else if (s_ack[busy_k]) begin
                e_ack = 1; e_data = sdata[busy_k]; nx_k = -1;
            end else if (age + 1 == TO) begin
                e_err = 1; nx_k = -1;
            end else nx_age = age + 1;
        end else if (m_cyc && m_stb) begin
            k = decode(m_addr);
            if (k < 0) nx_errp = 1;
            else begin
                e_stb[k] = 1; e_cyc[k] = 1; e_stall = s_stall[k];
                if (!s_stall[k]) begin nx_k = k; nx_age = 0; end
            end
        end
        if (!reset && s_stb[0] && !s_stall[0]) acc0++;
        chk("mdl_ack", m_ack, e_ack);
        chk("mdl_err", m_err, e_err);
        chk("mdl_stall", m_stall, e_stall);
        chk("mdl_data", m_data_in, e_data);
        chk("mdl_stb", s_stb, e_stb);
        chk("mdl_cyc", s_cyc, e_cyc);
        chk("mdl_addr", s_addr, m_addr);
        chk("mdl_wdata", s_data_out, m_data_out);
        chk("mdl_we", s_we, m_we);
        chk("mdl_excl", m_ack & m_err, 0);
    end

    // Commit the model's next transaction state on each active edge.
    always @(posedge clk) begin
        busy_k <= nx_k;
        age    <= nx_age;
        errp   <= nx_errp;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_cyc = 0; m_stb = 0; m_we = 0;
        s_ack = '0; s_stall = '0;
    endtask

    task automatic req(input logic [MW-1:0] a, input logic we);
        m_cyc = 1; m_stb = 1; m_addr = a; m_we = we;
        m_data_out = a ^ 32'hA5A5_0000;
    endtask

    int errc;
    int acc_base;

    initial begin
        reset = 1; idle(); m_addr = '0; m_data_out = '0;
        for (int k = 0; k < NS; k++) sdata[k] = 32'h1111_0000 + k;
        req(32'h2040_0004, 0);
        @(negedge clk);
        chk("rst_stb", s_stb, 0);
        chk("rst_cyc", s_cyc, 0);
        chk("rst_stall", m_stall, 0);
        tick(); tick();
        reset = 0; idle();

        // Read from slave1 with ack two cycles after accept.
        req(32'h2040_0004, 0); sdata[0] = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("t1_stb", s_stb, 4'b0010);
        chk("t1_stall", m_stall, 0);
        tick(); m_stb = 0;
        @(negedge clk);
        chk("t1_busy_stall", m_stall, 1);
        chk("t1_busy_stb", s_stb, 0);
        chk("t1_busy_cyc", s_cyc, 4'b0010);
        tick(); s_ack = 4'b0010; sdata[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_ack", m_ack, 1);
        chk("t1_data", m_data_in, 32'hDEAD_BEEF);
        tick(); idle();
        @(negedge clk);
        chk("t1_ack_pulse", m_ack, 0);
        chk("t1_data_zero", m_data_in, 0);
        tick();

        // Last word of slave0 (write), then first unmapped byte.
        req(32'h1000_3FFC, 1);
        @(negedge clk);
        chk("t2_stb", s_stb, 4'b0001);
        tick(); m_stb = 0; s_ack = 4'b0001; sdata[0] = 32'h1234_5678;
        @(negedge clk);
        chk("t2_ack", m_ack, 1);
        tick(); idle();
        req(32'h1000_4000, 0);
        @(negedge clk);
        chk("t2_miss_stb", s_stb, 0);
        chk("t2_miss_stall", m_stall, 0);
        chk("t2_miss_err0", m_err, 0);
        tick(); m_stb = 0;
        @(negedge clk);
        chk("t2_miss_err", m_err, 1);
        chk("t2_miss_ack", m_ack, 0);
        tick(); idle();
        @(negedge clk);
        chk("t2_err_pulse", m_err, 0);
        tick();

        // Slave0 stalls three cycles, then accepts once.
        acc_base = acc0;
        req(32'h1000_0010, 0); s_stall = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall", m_stall, 1);
            chk("t3_stb", s_stb, 4'b0001);
            tick();
        end
        s_stall = '0;
        @(negedge clk);
        chk("t3_go_stall", m_stall, 0);
        chk("t3_go_stb", s_stb, 4'b0001);
        tick(); m_stb = 0;
        @(negedge clk);
        chk("t3_busy_stb", s_stb, 0);
        tick(); s_ack = 4'b0001;
        @(negedge clk);
        chk("t3_ack", m_ack, 1);
        tick(); idle();
        chk("t3_one_txn", acc0 - acc_base, 1);

        // Slave0 never acks: error on the 16th busy cycle.
        req(32'h1000_0000, 0);
        @(negedge clk);
        tick(); m_stb = 0;
        errc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (m_err) begin errc = c; break; end
            tick();
        end
        chk("t4_err_cycle", errc, 16);
        tick(); idle();
        @(negedge clk);
        chk("t4_idle_err", m_err, 0);
        tick();
        req(32'h2040_0000, 0);
        @(negedge clk);
        chk("t4_next_stb", s_stb, 4'b0010);
        tick(); m_stb = 0; s_ack = 4'b0010; sdata[1] = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t4_next_ack", m_ack, 1);
        chk("t4_next_data", m_data_in, 32'hCAFE_F00D);
        tick(); idle();

        // Stray ack from a non-selected slave is ignored.
        req(32'h1000_0020, 0);
        @(negedge clk);
        tick(); m_stb = 0; s_ack = 4'b0010;
        @(negedge clk);
        chk("t5_stray", m_ack, 0);
        tick(); s_ack = 4'b0001; sdata[0] = 32'h55AA_55AA;
        @(negedge clk);
        chk("t5_ack", m_ack, 1);
        chk("t5_data", m_data_in, 32'h55AA_55AA);
        tick(); idle();

        // Ack on the timeout cycle wins.
        req(32'h1000_0030, 0);
        @(negedge clk);
        tick(); m_stb = 0;
        repeat (15) begin
            @(negedge clk);
            chk("t5_wait_err", m_err, 0);
            tick();
        end
        s_ack = 4'b0001;
        @(negedge clk);
        chk("t5_race_ack", m_ack, 1);
        chk("t5_race_err", m_err, 0);
        tick(); idle();

        // Master drops cyc mid-transaction: abort, ack suppressed.
        req(32'h1000_0040, 0);
        @(negedge clk);
        tick(); m_cyc = 0; m_stb = 0; s_ack = 4'b0001;
        @(negedge clk);
        chk("t6_abort_ack", m_ack, 0);
        chk("t6_abort_cyc", s_cyc, 0);
        tick(); idle();
        @(negedge clk);
        chk("t6_abort_idle", m_stall, 0);
        tick();

        // Reset while busy; a late ack afterwards is ignored.
        req(32'h1000_0050, 0);
        @(negedge clk);
        tick(); m_stb = 0;
        @(negedge clk);
        chk("t7_busy", m_stall, 1);
        tick(); reset = 1;
        @(negedge clk);
        chk("t7_rst_ack", m_ack, 0);
        chk("t7_rst_err", m_err, 0);
        chk("t7_rst_stall", m_stall, 0);
        chk("t7_rst_cyc", s_cyc, 0);
        chk("t7_rst_stb", s_stb, 0);
        chk("t7_rst_data", m_data_in, 0);
        tick(); reset = 0; m_cyc = 0; s_ack = 4'b0001;
        @(negedge clk);
        chk("t7_late_ack", m_ack, 0);
        chk("t7_late_stall", m_stall, 0);
        tick(); idle();
        req(32'h2040_0008, 0);
        @(negedge clk);
        chk("t7_new_stb", s_stb, 4'b0010);
        tick(); m_stb = 0; s_ack = 4'b0010;
        @(negedge clk);
        chk("t7_new_ack", m_ack, 1);
        tick(); idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
